// File: rtl/mem_pkg.sv
// Shared RAM bus types used by the hosts, the arbiter and the RAM device port.
package mem_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int MASK_W = DATA_W / 8;

  // Host-to-device request channel.
  typedef struct packed {
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [MASK_W-1:0] mask;
  } mem_h2d_t;

  // Device-to-host response channel.
  typedef struct packed {
    logic              gnt;
    logic              valid;
    logic [DATA_W-1:0] data;
    logic              error;
  } mem_d2h_t;

endpackage

// File: rtl/mem_arb2.sv
// mem_arb2: two-host to one-device arbiter for the shared RAM bus.
//
// Handshake: a host raises req with stable fields and holds them until it
// sees gnt; the request is accepted in the cycle where req and gnt are both
// high. The device answers every accepted request with exactly one valid
// pulse, in acceptance order. An in-order ID FIFO remembers which host owns
// each outstanding request so the valid pulse can be steered back to it.
//
// Build option: define MEM_ARB_RR_EN for round-robin tie breaking.
// Without it host 0 has fixed priority on a tie and host 1 may starve.
module mem_arb2
  import mem_pkg::*;
#(
  parameter int MAX_OUT = 4
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  mem_h2d_t h0_i,
  output mem_d2h_t h0_o,
  input  mem_h2d_t h1_i,
  output mem_d2h_t h1_o,
  output mem_h2d_t dev_o,
  input  mem_d2h_t dev_i,
  output logic     orphan_o
);

  localparam int PW = $clog2(MAX_OUT);
  localparam int CW = PW + 1;

  // Registered state.
  logic [CW-1:0]      occ_q;
  logic [PW-1:0]      wptr_q;
  logic [PW-1:0]      rptr_q;
  logic [MAX_OUT-1:0] id_q;
  logic               orphan_q;
`ifdef MEM_ARB_RR_EN
  logic               last_q;
`endif

  // Combinational decode.
  logic full;
  logic empty;
  logic el0;
  logic el1;
  logic win_vld;
  logic winner;
  logic acc;
  logic pop;
  logic head;
  logic orphan_set;

  // Eligibility, winner selection and FIFO push/pop decode.
  // Full comes from registered occupancy only, so dev_i.valid never reaches dev_o.req.
  always_comb begin
    full       = (occ_q == CW'(MAX_OUT));
    empty      = (occ_q == '0);
    el0        = h0_i.req & ~full & ~rst_i;
    el1        = h1_i.req & ~full & ~rst_i;
    win_vld    = el0 | el1;
    winner     = 1'b0;
    if (el0 && el1) begin
`ifdef MEM_ARB_RR_EN
      winner = ~last_q;
`else
      winner = 1'b0;
`endif
    end else begin
      winner = el1;
    end
    acc        = win_vld & dev_i.gnt;
    pop        = dev_i.valid & ~empty & ~rst_i;
    head       = id_q[rptr_q];
    orphan_set = dev_i.valid & empty & ~rst_i;
  end

  // Request mux to the device and response steering back to the hosts.
  always_comb begin
    dev_o       = winner ? h1_i : h0_i;
    dev_o.req   = win_vld;

    h0_o        = '0;
    h0_o.gnt    = acc & ~winner;
    h0_o.valid  = pop & ~head;
    h0_o.data   = dev_i.data;
    h0_o.error  = dev_i.error;

    h1_o        = '0;
    h1_o.gnt    = acc & winner;
    h1_o.valid  = pop & head;
    h1_o.data   = dev_i.data;
    h1_o.error  = dev_i.error;

    orphan_o    = orphan_q;
  end

  // ID FIFO pointers, entries and occupancy; push on accept, pop on response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      occ_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      id_q   <= '0;
    end else begin
      if (acc) begin
        id_q[wptr_q] <= winner;
        wptr_q       <= wptr_q + PW'(1);
      end
      if (pop) begin
        rptr_q <= rptr_q + PW'(1);
      end
      case ({acc, pop})
        2'b10:   occ_q <= occ_q + CW'(1);
        2'b01:   occ_q <= occ_q - CW'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

  // Sticky orphan flag: a response arrived with nothing outstanding.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      orphan_q <= 1'b0;
    end else if (orphan_set) begin
      orphan_q <= 1'b1;
    end
  end

`ifdef MEM_ARB_RR_EN
  // Round-robin memory of the last accepted host; reset to 1 so host 0 wins the first tie.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q <= 1'b1;
    end else if (acc) begin
      last_q <= winner;
    end
  end
`endif

endmodule

// File: doc/mem_arb2.md
# mem_arb2

Two-host to one-device arbiter for the shared RAM bus in `top`, sitting between two `mem_pkg` hosts (core data port and debug/DMA port) and the single RAM device port. It selects one request per cycle and tracks outstanding transactions in an in-order ID FIFO. Each device response (`valid`, `data`, `error`) is routed back to the host that issued the matching request. The device is assumed to return exactly one response per accepted request, in order, reads and writes alike.

## Interface
- `MAX_OUT`, default 4: maximum outstanding accepted-but-unanswered transactions; power of two, ≥2.
- `clk_i` in 1: clock, all logic on rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `h0_i` in `mem_h2d_t`: host 0 request (`req`, `we`, `addr`, `data`, `mask`).
- `h0_o` out `mem_d2h_t`: host 0 response (`gnt`, `valid`, `data`, `error`).
- `h1_i` in `mem_h2d_t`: host 1 request.
- `h1_o` out `mem_d2h_t`: host 1 response.
- `dev_o` out `mem_h2d_t`: device request.
- `dev_i` in `mem_d2h_t`: device response.
- `orphan_o` out 1: sticky flag, set when a device `valid` arrives with the ID FIFO empty.

## Operation
- Arbitration is combinational each cycle. Eligible = `hN_i.req` AND FIFO not full.
- Winner selection: if exactly one host is eligible, it wins. If both are eligible, the winner follows the policy in Configuration.
- `dev_o` carries the winner's request fields; `dev_o.req` = winner exists. With no winner, `dev_o.req`=0 and the other fields are don't-care, driven from host 0.
- Acceptance: `acc` = `dev_o.req` AND `dev_i.gnt`. `hN_o.gnt` = `acc` AND winner==N. The loser's `gnt` is 0 and it must hold its request stable.
- ID FIFO: depth `MAX_OUT`, 1-bit entries holding the winner index.
  - Push on `acc`. Pop on `dev_i.valid` when the FIFO is not empty.
  - Push and pop in the same cycle are both performed; occupancy is unchanged.
  - Occupancy counter is $clog2(`MAX_OUT`)+1 bits wide; read and write pointers wrap modulo `MAX_OUT`.
  - Full: occupancy==`MAX_OUT`. Both hosts are then ineligible, so `dev_o.req`=0. A pop in the same cycle does not lift full until the next cycle.
- Response routing: on `dev_i.valid` with the FIFO not empty, `hN_o.valid`=1 for N = FIFO head. `data` and `error` are copied from `dev_i` to both hosts; only the `valid` bit is steered.
- Orphan response: on `dev_i.valid` with the FIFO empty, neither host sees `valid`, the response is dropped and `orphan_o` sets. `orphan_o` clears only on reset.
- Policy state `last` (1 bit) updates only on `acc`, taking the value of the winner.

## Timing
- Request to device: 0 cycles, combinational from `hN_i` to `dev_o` and from `dev_i.gnt` to `hN_o.gnt`.
- Response to host: 0 cycles, combinational from `dev_i.valid` and FIFO head to `hN_o.valid`.
- End-to-end latency equals the device latency, e.g. 1 cycle with the simulation RAM.
- No combinational path from `dev_i.valid` to `dev_o.req`. Full status is registered occupancy only.
- Reset state:
  - FIFO empty, pointers 0, `last`=1 so host 0 wins the first tie, `orphan_o`=0.
  - While `rst_i`=1: all `gnt`, all `valid` and `dev_o.req` are forced to 0.
- Reset mid-operation: in-flight IDs are discarded. Device responses arriving after reset deasserts find the FIFO empty and set `orphan_o`. This is intended and is the defined detection mechanism.
- Sustained throughput: 1 accepted request per cycle while the FIFO is below full and `dev_i.gnt`=1.

## Configuration
- `MEM_ARB_RR_EN` defined:
  - Round-robin. On a tie, the host ≠ `last` wins.
  - A host that keeps requesting waits at most one accepted transaction.
- `MEM_ARB_RR_EN` undefined:
  - Fixed priority. Host 0 always wins a tie.
  - `last` register is not implemented. Host 1 may starve.

## Test plan
- Single host: h0 reads addr 0x10 with `gnt`=1 and device latency 1.
  - Expect `h0_o.gnt` in cycle 0 and `h0_o.valid` with the device data in cycle 1.
  - Expect no `h1_o.valid` and `orphan_o`=0.
- Tie, `MEM_ARB_RR_EN` defined: both hosts request continuously for 6 cycles.
  - Expect grants h0,h1,h0,h1,h0,h1, with responses steered in the same order.
- Tie, `MEM_ARB_RR_EN` undefined: both hosts request for 4 cycles.
  - Expect 4 grants to h0 and 0 to h1.
  - After h0 drops `req`, h1 is granted in the next cycle.
- Full: `MAX_OUT`=4, device withholds `valid`, h1 issues 4 requests.
  - Expect a 5th request from either host to see `gnt`=0 and `dev_o.req`=0.
  - One `valid` lands on h1; in the following cycle `gnt` resumes.
- Simultaneous push and pop at occupancy 2: `acc` and `dev_i.valid` in the same cycle.
  - Expect occupancy to stay 2 and response order to be preserved across pointer wrap, checked over 12 transactions.
- Reset mid-flight: 2 outstanding transactions, pulse `rst_i` for 1 cycle, device then returns 2 `valid`s.
  - Expect no host `valid` and `orphan_o`=1.
  - After a further `rst_i` pulse, `orphan_o`=0.
